// File: rtl/test42_slave.sv
`default_nettype none
// ============================================================================
//  Module   : test42_slave
//  Brief    : DEPTH x 32 register file with independent read and write ports.
//             Each port uses a req/ack handshake. Ack is a one-cycle
//             registered pulse, and requests are ignored while ack is high.
//             The read port returns data registered, read-before-write.
//  Revision : 1.0 - initial release
// ============================================================================
module test42_slave #(
  parameter int DEPTH    = 16,
  parameter int ADDR_LSB = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] test42_pioRegfileRead_addr,
  input  logic        test42_pioRegfileRead_req,
  output logic        test42_pioRegfileRead_ack,
  output logic [31:0] test42_pioRegfileRead_return,
  input  logic [31:0] test42_pioRegfileWrite_addr,
  input  logic [31:0] test42_pioRegfileWrite_data,
  input  logic        test42_pioRegfileWrite_req,
  output logic        test42_pioRegfileWrite_ack
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      mem_q [DEPTH];
  logic             rd_ack_q;
  logic             wr_ack_q;
  logic [31:0]      rd_data_q;

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_accept;
  logic             wr_accept;
  logic [31:0]      rd_data_d;

  // Only the index field of each address is decoded. Bits below it select
  // bytes within a word, and bits above it alias onto the same registers.
  assign rd_idx = test42_pioRegfileRead_addr[ADDR_LSB +: IDX_W];
  assign wr_idx = test42_pioRegfileWrite_addr[ADDR_LSB +: IDX_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{test42_pioRegfileRead_addr[31:ADDR_LSB+IDX_W],
                              test42_pioRegfileRead_addr[ADDR_LSB-1:0],
                              test42_pioRegfileWrite_addr[31:ADDR_LSB+IDX_W],
                              test42_pioRegfileWrite_addr[ADDR_LSB-1:0]};

  // While ack is high, req is still the previous transaction's req, so it is
  // not treated as a new request.
  assign rd_accept = test42_pioRegfileRead_req  & ~rd_ack_q;
  assign wr_accept = test42_pioRegfileWrite_req & ~wr_ack_q;

  // Read data comes from the current (pre-write) contents. Because of this, a
  // read and a write to the same index in the same cycle see the old value.
  assign rd_data_d = rd_accept ? mem_q[rd_idx] : rd_data_q;

  // Storage array: commit accepted writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_accept && (wr_idx == IDX_W'(i))) begin
          mem_q[i] <= test42_pioRegfileWrite_data;
        end
      end
    end
  end

  // Handshake acks and registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q  <= rd_accept;
      wr_ack_q  <= wr_accept;
      rd_data_q <= rd_data_d;
    end
  end

  assign test42_pioRegfileRead_ack    = rd_ack_q;
  assign test42_pioRegfileRead_return = rd_data_q;
  assign test42_pioRegfileWrite_ack   = wr_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_test42_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_test42_slave
//  Brief    : Self-checking bench for test42_slave. It runs directed scenarios
//             and then random traffic, and compares every cycle against a
//             behavioural register-file model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_test42_slave;

  localparam int DEPTH    = 16;
  localparam int ADDR_LSB = 2;

  logic        clk;
  logic        reset;
  logic [31:0] rd_addr;
  logic        rd_req;
  logic        rd_ack;
  logic [31:0] rd_ret;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_req;
  logic        wr_ack;

  int tests;
  int fails;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic        m_rack;
  logic        m_wack;
  logic [31:0] m_rret;

  test42_slave #(.DEPTH(DEPTH), .ADDR_LSB(ADDR_LSB)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .test42_pioRegfileRead_addr   (rd_addr),
    .test42_pioRegfileRead_req    (rd_req),
    .test42_pioRegfileRead_ack    (rd_ack),
    .test42_pioRegfileRead_return (rd_ret),
    .test42_pioRegfileWrite_addr  (wr_addr),
    .test42_pioRegfileWrite_data  (wr_data),
    .test42_pioRegfileWrite_req   (wr_req),
    .test42_pioRegfileWrite_ack   (wr_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> ADDR_LSB) % DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_rack = 1'b0;
    m_wack = 1'b0;
    m_rret = 32'h0;
  endtask

  // One clock edge: advance the model from the sampled inputs, then compare.
  task automatic step();
    @(posedge clk);
    if (rd_req && !m_rack) begin
      m_rret = m_mem[word_of(rd_addr)];
      m_rack = 1'b1;
    end else begin
      m_rack = 1'b0;
    end
    if (wr_req && !m_wack) begin
      m_mem[word_of(wr_addr)] = wr_data;
      m_wack = 1'b1;
    end else begin
      m_wack = 1'b0;
    end
    #1;
    check("rd_ack", {31'h0, rd_ack}, {31'h0, m_rack});
    check("wr_ack", {31'h0, wr_ack}, {31'h0, m_wack});
    check("rd_return", rd_ret, m_rret);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    wr_addr = addr; wr_data = data; wr_req = 1'b1;
    step();
    check("wr_ack_pulse", {31'h0, wr_ack}, 32'h1);
    @(negedge clk);
    wr_req = 1'b0;
    step();
    check("wr_ack_single", {31'h0, wr_ack}, 32'h0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    rd_addr = addr; rd_req = 1'b1;
    step();
    check("rd_ack_pulse", {31'h0, rd_ack}, 32'h1);
    check("rd_data", rd_ret, exp);
    @(negedge clk);
    rd_req = 1'b0;
    step();
    check("rd_ack_single", {31'h0, rd_ack}, 32'h0);
    check("rd_data_hold", rd_ret, exp);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    rd_addr = '0; rd_req = 1'b0;
    wr_addr = '0; wr_data = '0; wr_req = 1'b0;
    model_reset();
    #12;
    check("reset_rd_ack", {31'h0, rd_ack}, 32'h0);
    check("reset_wr_ack", {31'h0, wr_ack}, 32'h0);
    check("reset_rd_return", rd_ret, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Read right after reset release: unwritten register returns zero.
    do_read(32'd4, 32'h0);

    do_write(32'd8,  32'hDEADBEEF);
    do_write(32'd16, 32'h12345678);
    do_read(32'd8,  32'hDEADBEEF);
    do_read(32'd16, 32'h12345678);
    do_read(32'd8,  32'hDEADBEEF);
    do_read(32'd8 + DEPTH * 4, 32'hDEADBEEF);
    do_read(32'd9,  32'hDEADBEEF);

    // Continuously held request: ack alternates and is never high twice in a row.
    @(negedge clk);
    rd_addr = 32'd16; rd_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("hold_ack_pattern", {31'h0, rd_ack}, ((i % 2) == 0) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    rd_req = 1'b0;
    step();

    // Read and write to the same index accepted at the same edge.
    @(negedge clk);
    rd_addr = 32'd16; rd_req = 1'b1;
    wr_addr = 32'd16; wr_data = 32'hCAFEF00D; wr_req = 1'b1;
    step();
    check("rbw_old_value", rd_ret, 32'h12345678);
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    step();
    do_read(32'd16, 32'hCAFEF00D);

    // Asynchronous reset in mid-cycle while ack is high. The request stays
    // high through the reset and is taken as a new request afterwards.
    @(negedge clk);
    rd_addr = 32'd8; rd_req = 1'b1;
    step();
    check("pre_reset_ack", {31'h0, rd_ack}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_rst_ack", {31'h0, rd_ack}, 32'h0);
    check("async_rst_return", rd_ret, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("post_reset_new_req_ack", {31'h0, rd_ack}, 32'h1);
    check("post_reset_read8", rd_ret, 32'h0);
    @(negedge clk);
    rd_req = 1'b0;
    step();

    // Random traffic, with occasional asynchronous resets mixed in.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rand_rst_ack", {31'h0, rd_ack | wr_ack}, 32'h0);
        check("rand_rst_return", rd_ret, 32'h0);
        reset = 1'b1;
      end
      rd_req  = ($urandom_range(0, 3) != 0);
      wr_req  = ($urandom_range(0, 2) != 0);
      rd_addr = {$urandom_range(0, 7), 24'h0} | 32'($urandom_range(0, DEPTH * 4 - 1));
      wr_addr = {$urandom_range(0, 7), 24'h0} | 32'($urandom_range(0, DEPTH * 4 - 1));
      wr_data = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/test42_slave.md
TEST42_SLAVE -- requirements
Module: test42_slave

Interface
REQ-001 Parameter DEPTH, default 16: number of 32-bit registers in the file; power of two.
REQ-002 Parameter ADDR_LSB, default 2: byte-to-word shift; register index = addr[ADDR_LSB+log2(DEPTH)-1 : ADDR_LSB].
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 test42_pioRegfileRead_addr  input  32: byte address of the read.
REQ-006 test42_pioRegfileRead_req  input  1: read request, held high by the master until it sees ack.
REQ-007 test42_pioRegfileRead_ack  output  1: read completion pulse, registered.
REQ-008 test42_pioRegfileRead_return  output  32: read data, registered.
REQ-009 test42_pioRegfileWrite_addr  input  32: byte address of the write.
REQ-010 test42_pioRegfileWrite_data  input  32: write data.
REQ-011 test42_pioRegfileWrite_req  input  1: write request, held high by the master until it sees ack.
REQ-012 test42_pioRegfileWrite_ack  output  1: write completion pulse, registered.

Function
REQ-013 The block SHALL implement a DEPTH x 32 register file with independent read and write ports, each using the HSIMPLE req/ack protocol.
REQ-014 A request SHALL be accepted on a rising edge where req=1 and the corresponding ack=0.
REQ-015 On accepting a request, ack SHALL go high at that same edge, one cycle after req is first sampled high, and SHALL stay high for exactly one cycle.
REQ-016 While ack=1, req SHALL be ignored, because the master's req is still high for that cycle; a req still high on the following edge is treated as a new request.
REQ-017 An accepted write SHALL store write_data into the indexed register at the accepting edge.
REQ-018 An accepted read SHALL load the indexed register's value into read_return at the accepting edge.
REQ-019 read_return SHALL hold its value until the next accepted read.
REQ-020 Address bits below ADDR_LSB SHALL be ignored.
REQ-021 Address bits above the index range SHALL be ignored, so addresses alias modulo DEPTH*4 bytes.
REQ-022 Read and write ports SHALL operate concurrently.
REQ-023 If a read and a write to the same index are accepted at the same edge, the read SHALL return the pre-write value (read-before-write), and the write SHALL still take effect.
REQ-024 Reading a register never written since reset SHALL return 0x00000000.
REQ-025 There is no error or decode-failure signalling; every request completes.

Reset
REQ-026 While reset=0, asynchronously: all registers SHALL be 0, read_ack=0, write_ack=0 and read_return=0.
REQ-027 After reset deasserts, requests SHALL be accepted from the first rising edge.
REQ-028 A transaction interrupted by reset SHALL be abandoned.
REQ-029 After an interrupted transaction, no ack SHALL be produced for it, and its write (if not yet committed) SHALL be lost.
REQ-030 A req still high after reset is released SHALL be treated as a new request.

Verification
REQ-031 Scenario 1: write addr 8, data 0xDEADBEEF -> write_ack pulses high exactly one cycle, one cycle after req is sampled.
REQ-032 Scenario 2: then write addr 16, data 0x12345678 -> write_ack pulses exactly one cycle.
REQ-033 Scenario 3: read addr 8 -> read_ack pulses one cycle with read_return=0xDEADBEEF.
REQ-034 Scenario 4: then read addr 16 -> read_return=0x12345678.
REQ-035 Scenario 5: then read addr 8 again -> read_return=0xDEADBEEF.
REQ-036 Scenario 6: after reset, read addr 4 -> read_return=0.
REQ-037 Scenario 7: after writing 0xDEADBEEF to addr 8, read addr 8+DEPTH*4 (72) -> read_return=0xDEADBEEF (alias).
REQ-038 Scenario 8: read addr 9 -> read_return=0xDEADBEEF (low bits ignored).
REQ-039 Scenario 9: with req held high continuously for 6 cycles -> ack pulses on alternating cycles (high, low, high, ...), never two consecutive cycles.
REQ-040 Scenario 10: read and write both to addr 16 at the same edge, write data 0xCAFEF00D -> read_return=0x12345678.
REQ-041 Scenario 11: a subsequent read of addr 16 -> read_return=0xCAFEF00D.
REQ-042 Scenario 12: assert reset=0 asynchronously mid-cycle while ack=1 -> ack and read_return drop to 0 immediately, and a following read of addr 8 returns 0.
